// File: rtl/lcd_ctrl_if.sv
// LSU-to-LCD-controller bus: the LCD control word in, pad drive and status out.
`timescale 1ns/1ps
interface lcd_ctrl_if;
  logic [31:0] i_lcd_reg;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic        o_lcd_on;
  logic        o_busy;
  logic        o_done;

  modport master (
    output i_lcd_reg,
    input  o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_done
  );

  modport slave (
    input  i_lcd_reg,
    output o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_done
  );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-style write sequencer: turns each LSU request toggle into a timed
// setup / enable / hold / execute cycle. Define LCD_INIT_SEQ_EN for power-on init writes.
`timescale 1ns/1ps
module lcd_ctrl #(
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned EN_CYC        = 25,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned LONG_EXEC_CYC = 82000,
  parameter int unsigned PWRUP_CYC     = 750000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  lcd_ctrl_if.slave   bus
);

  localparam int unsigned MAX_CYC = (LONG_EXEC_CYC > PWRUP_CYC) ? LONG_EXEC_CYC : PWRUP_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PWRUP, S_SETUP, S_PULSE, S_HOLD, S_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tog_q, tog_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             on_q, on_d;
  logic             long_cmd_c;

`ifdef LCD_INIT_SEQ_EN
  logic [1:0] idx_q, idx_d;
  logic       init_q, init_d;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction
`endif

  // Clear display / return home need the long execution wait.
  assign long_cmd_c = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tog_d   = tog_q;
    data_d  = data_q;
    rs_d    = rs_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    on_d    = bus.i_lcd_reg[31];
`ifdef LCD_INIT_SEQ_EN
    idx_d   = idx_q;
    init_d  = init_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.i_lcd_reg[30] != tog_q) begin
          tog_d   = bus.i_lcd_reg[30];
          data_d  = bus.i_lcd_reg[7:0];
          rs_d    = bus.i_lcd_reg[9];
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
          state_d = S_SETUP;
        end
      end
`ifdef LCD_INIT_SEQ_EN
      S_PWRUP: begin
        if (cnt_q == '0) begin
          data_d  = init_cmd(2'd0);
          rs_d    = 1'b0;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
          state_d = S_SETUP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      S_SETUP: begin
        if (cnt_q == '0) begin
          en_d    = 1'b1;
          cnt_d   = CNT_W'(EN_CYC - 1);
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          en_d    = 1'b0;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          cnt_d   = long_cmd_c ? CNT_W'(LONG_EXEC_CYC - 1) : CNT_W'(EXEC_CYC - 1);
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
`ifdef LCD_INIT_SEQ_EN
          if (init_q && idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            data_d  = init_cmd(idx_q + 2'd1);
            rs_d    = 1'b0;
            cnt_d   = CNT_W'(SETUP_CYC - 1);
            state_d = S_SETUP;
          end else begin
            init_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
`else
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
`ifdef LCD_INIT_SEQ_EN
      state_q <= S_PWRUP;
      cnt_q   <= CNT_W'(PWRUP_CYC - 1);
      busy_q  <= 1'b1;
      idx_q   <= 2'd0;
      init_q  <= 1'b1;
`else
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
`endif
      tog_q   <= 1'b0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
`ifdef LCD_INIT_SEQ_EN
      idx_q   <= idx_d;
      init_q  <= init_d;
`endif
      tog_q   <= tog_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      done_q  <= done_d;
      on_q    <= on_d;
    end
  end

  assign bus.o_lcd_data = data_q;
  assign bus.o_lcd_rs   = rs_q;
  assign bus.o_lcd_rw   = 1'b0;
  assign bus.o_lcd_en   = en_q;
  assign bus.o_lcd_on   = on_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing (SETUP=2 EN=3 HOLD=1 EXEC=5 LONG=20).
`timescale 1ns/1ps
module tb_lcd_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lcd_ctrl_if bus();

  lcd_ctrl #(
    .SETUP_CYC(2), .EN_CYC(3), .HOLD_CYC(1),
    .EXEC_CYC(5), .LONG_EXEC_CYC(20), .PWRUP_CYC(10)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks one transaction from its first busy cycle (c=0) to the o_done cycle,
  // optionally rewriting the control word at two chosen cycles.
  task automatic observe(input logic [31:0] m1v, input int m1c,
                         input logic [31:0] m2v, input int m2c,
                         output int done_at, output int en_start, output int en_len,
                         output int busy_len, output logic [7:0] d0, output logic rs0,
                         output bit stable, output logic busy_at_done);
    done_at = -1; en_start = -1; en_len = 0; busy_len = 0;
    d0 = bus.o_lcd_data; rs0 = bus.o_lcd_rs; stable = 1'b1; busy_at_done = 1'bx;
    for (int c = 0; c < 100; c++) begin
      if (bus.o_done === 1'b1) begin
        done_at = c;
        busy_at_done = bus.o_busy;
        break;
      end
      if (bus.o_busy === 1'b1) busy_len++;
      if (bus.o_lcd_en === 1'b1) begin
        if (en_start < 0) en_start = c;
        en_len++;
      end
      if (bus.o_lcd_data !== d0 || bus.o_lcd_rs !== rs0) stable = 1'b0;
      if (c == m1c) bus.i_lcd_reg = m1v;
      if (c == m2c) bus.i_lcd_reg = m2v;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.i_lcd_reg = 32'h0;
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_lcd_en !== 1'b0) begin n_err++; $display("FAIL reset_en got %b want 0", bus.o_lcd_en); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
    n_cmp++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.o_done); end
    n_cmp++; if (bus.o_lcd_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", bus.o_lcd_data); end
    n_cmp++; if (bus.o_lcd_rs !== 1'b0) begin n_err++; $display("FAIL reset_rs got %b want 0", bus.o_lcd_rs); end
    n_cmp++; if (bus.o_lcd_on !== 1'b0) begin n_err++; $display("FAIL reset_on got %b want 0", bus.o_lcd_on); end
    n_cmp++; if (bus.o_lcd_rw !== 1'b0) begin n_err++; $display("FAIL reset_rw got %b want 0", bus.o_lcd_rw); end
    repeat (3) tick();
    rst_n = 1'b1;
    tick(); tick();
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got %b want 0", bus.o_busy); end
  endtask

  task automatic test_basic();
    int da, es, el, bl; logic [7:0] d0; logic r0; bit st; logic bd;
    n_cmp++; if (bus.o_lcd_on !== 1'b0) begin n_err++; $display("FAIL basic_on_before got %b want 0", bus.o_lcd_on); end
    bus.i_lcd_reg = 32'hC000_0241;
    tick();
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_rise got %b want 1", bus.o_busy); end
    n_cmp++; if (bus.o_lcd_on !== 1'b1) begin n_err++; $display("FAIL basic_on got %b want 1", bus.o_lcd_on); end
    n_cmp++; if (bus.o_lcd_en !== 1'b0) begin n_err++; $display("FAIL basic_en_setup got %b want 0", bus.o_lcd_en); end
    observe(32'h0, -1, 32'h0, -1, da, es, el, bl, d0, r0, st, bd);
    n_cmp++; if (d0 !== 8'h41) begin n_err++; $display("FAIL basic_data got %h want 41", d0); end
    n_cmp++; if (r0 !== 1'b1) begin n_err++; $display("FAIL basic_rs got %b want 1", r0); end
    n_cmp++; if (es !== 2) begin n_err++; $display("FAIL basic_en_start got %0d want 2", es); end
    n_cmp++; if (el !== 3) begin n_err++; $display("FAIL basic_en_len got %0d want 3", el); end
    n_cmp++; if (da !== 11) begin n_err++; $display("FAIL basic_done_at got %0d want 11", da); end
    n_cmp++; if (bl !== 11) begin n_err++; $display("FAIL basic_busy_len got %0d want 11", bl); end
    n_cmp++; if (bd !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done got %b want 0", bd); end
    n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL basic_pins_stable got %b want 1", st); end
    tick();
    n_cmp++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got %b want 0", bus.o_done); end
    n_cmp++; if (bus.o_lcd_data !== 8'h41) begin n_err++; $display("FAIL basic_data_kept got %h want 41", bus.o_lcd_data); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL basic_no_retrigger got %b want 0", bus.o_busy); end
  endtask

  task automatic test_long_wait();
    int da, es, el, bl; logic [7:0] d0; logic r0; bit st; logic bd;
    logic [31:0] regs [4] = '{32'h8000_0001, 32'hC000_0004, 32'h8000_0201, 32'hC000_0003};
    int          want [4] = '{26, 11, 11, 26};
    for (int i = 0; i < 4; i++) begin
      bus.i_lcd_reg = regs[i];
      tick();
      observe(32'h0, -1, 32'h0, -1, da, es, el, bl, d0, r0, st, bd);
      n_cmp++; if (da !== want[i]) begin n_err++; $display("FAIL long_done_at[%0d] got %0d want %0d", i, da, want[i]); end
      n_cmp++; if (d0 !== regs[i][7:0] || r0 !== regs[i][9]) begin n_err++; $display("FAIL long_pins[%0d] got %h/%b want %h/%b", i, d0, r0, regs[i][7:0], regs[i][9]); end
      tick();
    end
  endtask

  task automatic test_data_change();
    int da, es, el, bl; logic [7:0] d0; logic r0; bit st; logic bd; bit any_busy;
    bus.i_lcd_reg = 32'h8000_0277;
    tick();
    observe(32'h8000_0055, 3, 32'h0, -1, da, es, el, bl, d0, r0, st, bd);
    n_cmp++; if (d0 !== 8'h77) begin n_err++; $display("FAIL chg_data got %h want 77", d0); end
    n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL chg_pins_stable got %b want 1", st); end
    n_cmp++; if (da !== 11) begin n_err++; $display("FAIL chg_done_at got %0d want 11", da); end
    any_busy = 1'b0;
    repeat (5) begin tick(); if (bus.o_busy !== 1'b0) any_busy = 1'b1; end
    n_cmp++; if (any_busy !== 1'b0) begin n_err++; $display("FAIL chg_no_second got %b want 0", any_busy); end
    n_cmp++; if (bus.o_lcd_data !== 8'h77) begin n_err++; $display("FAIL chg_idle_data got %h want 77", bus.o_lcd_data); end
  endtask

  task automatic test_double_toggle();
    int da, es, el, bl; logic [7:0] d0; logic r0; bit st; logic bd; bit any_busy;
    bus.i_lcd_reg = 32'hC000_0010;
    tick();
    observe(32'h8000_0010, 2, 32'hC000_0010, 5, da, es, el, bl, d0, r0, st, bd);
    n_cmp++; if (da !== 11) begin n_err++; $display("FAIL dbl_done_at got %0d want 11", da); end
    any_busy = 1'b0;
    repeat (5) begin tick(); if (bus.o_busy !== 1'b0) any_busy = 1'b1; end
    n_cmp++; if (any_busy !== 1'b0) begin n_err++; $display("FAIL dbl_cancel got %b want 0", any_busy); end
  endtask

  task automatic test_back_to_back();
    int da, es, el, bl; logic [7:0] d0; logic r0; bit st; logic bd;
    bus.i_lcd_reg = 32'h8000_0020;
    tick();
    observe(32'hC000_0233, 3, 32'h0, -1, da, es, el, bl, d0, r0, st, bd);
    n_cmp++; if (d0 !== 8'h20 || st !== 1'b1) begin n_err++; $display("FAIL b2b_first_data got %h stable %b want 20 stable 1", d0, st); end
    n_cmp++; if (da !== 11) begin n_err++; $display("FAIL b2b_first_done got %0d want 11", da); end
    tick();
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL b2b_second_start got %b want 1", bus.o_busy); end
    observe(32'h0, -1, 32'h0, -1, da, es, el, bl, d0, r0, st, bd);
    n_cmp++; if (d0 !== 8'h33 || r0 !== 1'b1) begin n_err++; $display("FAIL b2b_second_pins got %h/%b want 33/1", d0, r0); end
    n_cmp++; if (da !== 11) begin n_err++; $display("FAIL b2b_second_done got %0d want 11", da); end
    tick();
  endtask

  task automatic test_reset_mid();
    int da, es, el, bl; logic [7:0] d0; logic r0; bit st; logic bd; bit saw;
    bus.i_lcd_reg = 32'h8000_0244;
    tick(); tick(); tick();
    n_cmp++; if (bus.o_lcd_en !== 1'b1) begin n_err++; $display("FAIL rstmid_in_pulse got %b want 1", bus.o_lcd_en); end
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_lcd_en !== 1'b0) begin n_err++; $display("FAIL rstmid_en got %b want 0", bus.o_lcd_en); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", bus.o_busy); end
    n_cmp++; if (bus.o_lcd_data !== 8'h00) begin n_err++; $display("FAIL rstmid_data got %h want 00", bus.o_lcd_data); end
    saw = 1'b0;
    repeat (3) begin tick(); if (bus.o_done !== 1'b0) saw = 1'b1; end
    rst_n = 1'b1;
    repeat (4) begin tick(); if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) saw = 1'b1; end
    n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL rstmid_no_done got %b want 0", saw); end
    bus.i_lcd_reg = 32'hC000_0246;
    tick();
    observe(32'h0, -1, 32'h0, -1, da, es, el, bl, d0, r0, st, bd);
    n_cmp++; if (d0 !== 8'h46 || r0 !== 1'b1) begin n_err++; $display("FAIL rstmid_fresh_pins got %h/%b want 46/1", d0, r0); end
    n_cmp++; if (da !== 11 || el !== 3) begin n_err++; $display("FAIL rstmid_fresh_timing got %0d/%0d want 11/3", da, el); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_wait();
    test_data_change();
    test_double_toggle();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
